// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU handshake, branch resolve, store lane alignment.
// Optional MISALIGN_CHECK_EN adds misalign_o and suppresses misaligned side effects.
package ex_stage_pipe_pkg;
  localparam logic [4:0] EX_ADD  = 5'd0;
  localparam logic [4:0] EX_ADDI = 5'd1;
  localparam logic [4:0] EX_LB   = 5'd2;
  localparam logic [4:0] EX_LH   = 5'd3;
  localparam logic [4:0] EX_LW   = 5'd4;
  localparam logic [4:0] EX_LBU  = 5'd5;
  localparam logic [4:0] EX_LHU  = 5'd6;
  localparam logic [4:0] EX_SB   = 5'd7;
  localparam logic [4:0] EX_SH   = 5'd8;
  localparam logic [4:0] EX_SW   = 5'd9;
  localparam logic [4:0] EX_BEQ  = 5'd10;
  localparam logic [4:0] EX_BNE  = 5'd11;
  localparam logic [4:0] EX_BLT  = 5'd12;
  localparam logic [4:0] EX_BGE  = 5'd13;
  localparam logic [4:0] EX_BLTU = 5'd14;
  localparam logic [4:0] EX_BGEU = 5'd15;
  localparam logic [4:0] EX_JAL  = 5'd16;
  localparam logic [4:0] EX_JALR = 5'd17;
  localparam logic [3:0] ALU_ADD = 4'd0;
endpackage

module ex_stage_pipe
  import ex_stage_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  localparam int BE_W   = XLEN / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [4:0]         ex_code_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    reg1_rdata_i,
  input  logic [XLEN-1:0]    reg2_rdata_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic               reg_we_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  output logic               alu_req_o,
  output logic [XLEN-1:0]    alu_data1_o,
  output logic [XLEN-1:0]    alu_data2_o,
  output logic [3:0]         alu_op_o,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic               alu_busy_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic [XLEN-1:0]    mem_wdata_o,
  output logic [BE_W-1:0]    mem_be_o,
  output logic [1:0]         mem_size_o,
  output logic               mem_uns_o,
  output logic [XLEN-1:0]    reg_wdata_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               hold_flag_o,
  output logic               jump_flag_o,
  output logic [XLEN-1:0]    jump_addr_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic               misalign_o
`endif
);

  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    IDLE,
    ALU_WAIT,
    OUT_STALL
  } state_t;

  state_t state;

  logic [4:0]         op_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    rs1_q;
  logic [XLEN-1:0]    rs2_q;
  logic [XLEN-1:0]    imm_q;
  logic               we_q;
  logic [RADDR_W-1:0] waddr_q;

  logic               idle;
  logic [4:0]         cur_op;
  logic [XLEN-1:0]    cur_pc;
  logic [XLEN-1:0]    cur_rs1;
  logic [XLEN-1:0]    cur_rs2;
  logic [XLEN-1:0]    cur_imm;
  logic               cur_we;
  logic [RADDR_W-1:0] cur_waddr;

  logic can_load;
  logic accept;
  logic capture;

  logic is_add, is_addi, is_ld, is_st;
  logic is_br, is_jal, is_jalr, is_uns;
  logic taken;
  logic [1:0] sz;

  logic eq, lt, ltu;
  logic [XLEN-1:0] sum_ri;
  logic [XLEN-1:0] pc_tgt;
  logic [XLEN-1:0] target;
  logic [OFF_W-1:0] off;
  logic [BE_W-1:0]  be_base;
  logic [BE_W-1:0]  be;
  logic [XLEN-1:0]  st_data;
  logic [XLEN-1:0]  wb_data;
  logic             mis;

  // In ALU_WAIT the latched copy keeps operands stable.
  assign idle      = (state == IDLE);
  assign cur_op    = idle ? ex_code_i    : op_q;
  assign cur_pc    = idle ? pc_i         : pc_q;
  assign cur_rs1   = idle ? reg1_rdata_i : rs1_q;
  assign cur_rs2   = idle ? reg2_rdata_i : rs2_q;
  assign cur_imm   = idle ? imm_i        : imm_q;
  assign cur_we    = idle ? reg_we_i     : we_q;
  assign cur_waddr = idle ? reg_waddr_i  : waddr_q;

  assign can_load    = !out_valid_o || out_ready_i;
  assign in_ready_o  = idle && can_load;
  assign hold_flag_o = !in_ready_o;
  assign accept      = in_ready_o && in_valid_i && !flush_i;
  assign alu_req_o   = !flush_i && (accept || state == ALU_WAIT);
  assign alu_op_o    = ALU_ADD;
  assign capture     = !flush_i && !alu_busy_i &&
                       (accept || (state == ALU_WAIT && can_load));

  assign eq     = (cur_rs1 == cur_rs2);
  assign lt     = ($signed(cur_rs1) < $signed(cur_rs2));
  assign ltu    = (cur_rs1 < cur_rs2);
  assign sum_ri = cur_rs1 + cur_imm;
  assign pc_tgt = cur_pc + cur_imm;
  assign target = is_jalr ? {sum_ri[XLEN-1:1], 1'b0} : pc_tgt;

  always_comb begin
    is_add  = 1'b0;
    is_addi = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    is_uns  = 1'b0;
    taken   = 1'b0;
    sz      = 2'd0;
    case (cur_op)
      EX_ADD:  is_add = 1'b1;
      EX_ADDI: is_addi = 1'b1;
      EX_LB:   is_ld = 1'b1;
      EX_LH:   begin is_ld = 1'b1; sz = 2'd1; end
      EX_LW:   begin is_ld = 1'b1; sz = 2'd2; end
      EX_LBU:  begin is_ld = 1'b1; is_uns = 1'b1; end
      EX_LHU:  begin is_ld = 1'b1; is_uns = 1'b1; sz = 2'd1; end
      EX_SB:   is_st = 1'b1;
      EX_SH:   begin is_st = 1'b1; sz = 2'd1; end
      EX_SW:   begin is_st = 1'b1; sz = 2'd2; end
      EX_BEQ:  begin is_br = 1'b1; taken = eq; end
      EX_BNE:  begin is_br = 1'b1; taken = !eq; end
      EX_BLT:  begin is_br = 1'b1; taken = lt; end
      EX_BGE:  begin is_br = 1'b1; taken = !lt; end
      EX_BLTU: begin is_br = 1'b1; taken = ltu; end
      EX_BGEU: begin is_br = 1'b1; taken = !ltu; end
      EX_JAL:  begin is_jal = 1'b1; taken = 1'b1; end
      EX_JALR: begin is_jalr = 1'b1; taken = 1'b1; end
      default: ;
    endcase
  end

  // Branches and jumps borrow the ALU for the link value pc+4.
  always_comb begin
    alu_data1_o = '0;
    alu_data2_o = '0;
    unique case (1'b1)
      is_add: begin
        alu_data1_o = cur_rs1;
        alu_data2_o = cur_rs2;
      end
      (is_addi | is_ld | is_st): begin
        alu_data1_o = cur_rs1;
        alu_data2_o = cur_imm;
      end
      (is_br | is_jal | is_jalr): begin
        alu_data1_o = cur_pc;
        alu_data2_o = XLEN'(4);
      end
      default: ;
    endcase
  end

  assign off = alu_result_i[OFF_W-1:0];

  always_comb begin
    be_base = '0;
    st_data = '0;
    unique case (sz)
      2'd1: begin
        be_base = BE_W'(2'b11);
        st_data = {(XLEN/16){cur_rs2[15:0]}};
      end
      2'd2: begin
        be_base = BE_W'(4'hF);
        st_data = {(XLEN/32){cur_rs2[31:0]}};
      end
      default: begin
        be_base = BE_W'(1'b1);
        st_data = {BE_W{cur_rs2[7:0]}};
      end
    endcase
  end

  assign be = be_base << off;

  always_comb begin
    wb_data = '0;
    unique case (1'b1)
      (is_add | is_addi | is_jal | is_jalr): wb_data = alu_result_i;
      default: ;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  assign mis = (sz == 2'd1 && alu_result_i[0]) ||
               (sz == 2'd2 && alu_result_i[1:0] != 2'd0) ||
               (taken && target[1]);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      out_valid_o <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      mem_size_o  <= 2'd0;
      mem_uns_o   <= 1'b0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      jump_flag_o <= 1'b0;
      jump_addr_o <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_o  <= 1'b0;
`endif
    end else if (flush_i) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      reg_we_o    <= 1'b0;
      jump_flag_o <= 1'b0;
    end else begin
      jump_flag_o <= 1'b0;
      if (accept) begin
        op_q    <= ex_code_i;
        pc_q    <= pc_i;
        rs1_q   <= reg1_rdata_i;
        rs2_q   <= reg2_rdata_i;
        imm_q   <= imm_i;
        we_q    <= reg_we_i;
        waddr_q <= reg_waddr_i;
      end
      if (capture) begin
        state       <= out_ready_i ? IDLE : OUT_STALL;
        out_valid_o <= 1'b1;
        mem_req_o   <= (is_ld | is_st) && !mis;
        mem_we_o    <= is_st && !mis;
        mem_addr_o  <= (is_ld | is_st) ? alu_result_i : '0;
        mem_wdata_o <= is_st ? st_data : '0;
        mem_be_o    <= is_st ? be : '0;
        mem_size_o  <= sz;
        mem_uns_o   <= is_uns;
        reg_wdata_o <= wb_data;
        reg_we_o    <= cur_we && !is_st && !is_br && !mis;
        reg_waddr_o <= cur_waddr;
        jump_flag_o <= taken && !mis;
        jump_addr_o <= taken ? target : '0;
`ifdef MISALIGN_CHECK_EN
        misalign_o  <= mis;
`endif
      end else begin
        if (out_ready_i)
          out_valid_o <= 1'b0;
        unique case (state)
          IDLE: begin
            if (accept)
              state <= ALU_WAIT;
            else if (!can_load)
              state <= OUT_STALL;
          end
          ALU_WAIT: state <= ALU_WAIT;
          OUT_STALL: begin
            if (out_ready_i)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe with a bench-side adder standing in for the ALU.
module tb_ex_stage_pipe;
  import ex_stage_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [4:0]  ex_code_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] reg1_rdata_i = '0;
  logic [31:0] reg2_rdata_i = '0;
  logic [31:0] imm_i = '0;
  logic        reg_we_i = 1'b1;
  logic [4:0]  reg_waddr_i = 5'd1;
  logic        alu_req_o;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_result_i;
  logic        alu_busy_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  mem_size_o;
  logic        mem_uns_o;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  assign alu_result_i = alu_data1_o + alu_data2_o;

  always #5 clk = ~clk;

  ex_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ex_code_i(ex_code_i), .pc_i(pc_i),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .imm_i(imm_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .alu_req_o(alu_req_o), .alu_data1_o(alu_data1_o),
    .alu_data2_o(alu_data2_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_busy_i(alu_busy_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_size_o(mem_size_o), .mem_uns_o(mem_uns_o),
    .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .hold_flag_o(hold_flag_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o)
`ifdef MISALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  typedef struct {
    logic [31:0] wd;
    logic        we;
    logic [4:0]  wa;
    logic        req;
    logic        mwe;
    logic [1:0]  sz;
    logic        uns;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        jf;
    logic [31:0] ja;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s got %0h want %0h", tag, obs, exp);
  endtask

  function automatic exp_t model();
    exp_t e;
    logic [31:0] s, tgt;
    logic ld, st, br, tk;
    logic [7:0] b8;
    logic [3:0] base;
    s  = reg1_rdata_i + imm_i;
    ld = ex_code_i inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
    st = ex_code_i inside {EX_SB, EX_SH, EX_SW};
    br = ex_code_i inside {EX_BEQ, EX_BNE, EX_BLT, EX_BGE, EX_BLTU, EX_BGEU};
    case (ex_code_i)
      EX_BEQ:  tk = reg1_rdata_i == reg2_rdata_i;
      EX_BNE:  tk = reg1_rdata_i != reg2_rdata_i;
      EX_BLT:  tk = $signed(reg1_rdata_i) < $signed(reg2_rdata_i);
      EX_BGE:  tk = $signed(reg1_rdata_i) >= $signed(reg2_rdata_i);
      EX_BLTU: tk = reg1_rdata_i < reg2_rdata_i;
      EX_BGEU: tk = reg1_rdata_i >= reg2_rdata_i;
      EX_JAL, EX_JALR: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tgt = (ex_code_i == EX_JALR) ? (s & ~32'd1) : pc_i + imm_i;
    e.addr = (ld | st) ? s : 32'd0;
    case (ex_code_i)
      EX_LH, EX_LHU, EX_SH: e.sz = 2'd1;
      EX_LW, EX_SW:         e.sz = 2'd2;
      default:              e.sz = 2'd0;
    endcase
    e.mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    e.mis = (e.sz == 2'd1 && e.addr[0]) ||
            (e.sz == 2'd2 && e.addr[1:0] != 2'd0) || (tk && tgt[1]);
`endif
    e.req = (ld | st) && !e.mis;
    e.mwe = st && !e.mis;
    e.uns = ex_code_i inside {EX_LBU, EX_LHU};
    base = (e.sz == 2'd2) ? 4'hF : (e.sz == 2'd1) ? 4'h3 : 4'h1;
    b8 = {4'h0, base} << e.addr[1:0];
    e.be = st ? b8[3:0] : 4'h0;
    case (ex_code_i)
      EX_SB:   e.wdata = {4{reg2_rdata_i[7:0]}};
      EX_SH:   e.wdata = {2{reg2_rdata_i[15:0]}};
      EX_SW:   e.wdata = reg2_rdata_i;
      default: e.wdata = 32'd0;
    endcase
    case (ex_code_i)
      EX_ADD:          e.wd = reg1_rdata_i + reg2_rdata_i;
      EX_ADDI:         e.wd = s;
      EX_JAL, EX_JALR: e.wd = pc_i + 32'd4;
      default:         e.wd = 32'd0;
    endcase
    e.we = reg_we_i && !st && !br && !e.mis;
    e.wa = reg_waddr_i;
    e.jf = tk && !e.mis;
    e.ja = tk ? tgt : 32'd0;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    last_acc = in_valid_i && in_ready_o && !flush_i;
    if (last_acc) sb.push_back(model());
    if (out_valid_o && out_ready_i && !flush_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wb", {reg_we_o, reg_waddr_o, reg_wdata_o}, {e.we, e.wa, e.wd});
        chk("mem", {mem_req_o, mem_we_o, mem_size_o, mem_uns_o, mem_be_o,
                    mem_addr_o, mem_wdata_o},
                   {e.req, e.mwe, e.sz, e.uns, e.be, e.addr, e.wdata});
        chk("jump", {jump_flag_o, jump_addr_o}, {e.jf, e.ja});
`ifdef MISALIGN_CHECK_EN
        chk("misalign", misalign_o, e.mis);
`endif
      end
    end
    if (flush_i || !rst_n) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im);
    ex_code_i = op;
    pc_i = pc;
    reg1_rdata_i = r1;
    reg2_rdata_i = r2;
    imm_i = im;
    in_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) begin
        in_valid_i = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid_i = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_hold", hold_flag_o, 0);
    chk("rst_jump", jump_flag_o, 0);
    chk("rst_req", alu_req_o, 0);

    issue(EX_ADD, 32'h0, 32'd5, 32'd7, 32'd0);
    chk("add_lat", out_valid_o, 1);
    chk("add_wd", reg_wdata_o, 32'd12);
    chk("add_hold", hold_flag_o, 0);
    tick();

    // ADDI with the ALU busy for three cycles
    alu_busy_i = 1'b1;
    issue(EX_ADDI, 32'h0, 32'h100, 32'd0, 32'h20);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) alu_busy_i = 1'b0;
      #1;
      if (hold_flag_o) cnt++;
      chk("wait_op1", alu_data1_o, 32'h100);
      tick();
    end
    chk("busy_hold_cycles", cnt, 3);
    chk("busy_ready", in_ready_o, 1);
    chk("busy_wd", reg_wdata_o, 32'h120);
    tick();

    issue(EX_SB, 32'h0, 32'h1000, 32'hAB, 32'd3);
    chk("sb_be", mem_be_o, 4'b1000);
    chk("sb_wdata", mem_wdata_o, 32'hABABABAB);
    issue(EX_SH, 32'h0, 32'h2000, 32'h1234, 32'd3);
    issue(EX_SW, 32'h0, 32'h3000, 32'hDEADBEEF, 32'd4);
    issue(EX_LBU, 32'h0, 32'h10, 32'd0, 32'd1);
    issue(EX_LH, 32'h0, 32'h10, 32'd0, 32'd2);

    issue(EX_BNE, 32'h80, 32'd1, 32'd2, 32'h10);
    chk("bne_flag", jump_flag_o, 1);
    chk("bne_addr", jump_addr_o, 32'h90);
    tick();
    chk("bne_pulse", jump_flag_o, 0);
    issue(EX_BEQ, 32'h80, 32'd1, 32'd2, 32'h10);
    chk("beq_flag", jump_flag_o, 0);
    issue(EX_BLT, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
    issue(EX_BLTU, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
    issue(EX_BGEU, 32'h100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0);
    issue(EX_JAL, 32'hFFFFFFF8, 32'd0, 32'd0, 32'h10);
    issue(EX_JALR, 32'h40, 32'h203, 32'd0, 32'd0);
`ifndef MISALIGN_CHECK_EN
    chk("jalr_addr", jump_addr_o, 32'h202);
`endif
    chk("jalr_wd", reg_wdata_o, 32'h44);
    tick();

    // back-to-back throughput
    cnt = 0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_code_i = EX_ADDI;
      reg1_rdata_i = 32'(i * 16);
      imm_i = 32'd1;
      tick();
      if (last_acc) cnt++;
    end
    in_valid_i = 1'b0;
    chk("throughput", cnt, 4);
    tick();

    // output stall, blocked intake, then release
    out_ready_i = 1'b0;
    issue(EX_ADD, 32'h0, 32'd100, 32'd23, 32'd0);
    ex_code_i = EX_ADD;
    in_valid_i = 1'b1;
    tick();
    chk("stall_nacc", last_acc, 0);
    chk("stall_hold", hold_flag_o, 1);
    chk("stall_data", reg_wdata_o, 32'd123);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("stall_released", in_ready_o, 1);

    // LW stalled then flushed
    out_ready_i = 1'b0;
    issue(EX_LW, 32'h0, 32'h400, 32'd0, 32'd8);
    tick();
    chk("lw_stall_valid", out_valid_o, 1);
    chk("lw_stall_ready", in_ready_o, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    chk("flush_valid", out_valid_o, 0);
    chk("flush_ready", in_ready_o, 1);

    // flush kills a pending taken branch in ALU_WAIT
    alu_busy_i = 1'b1;
    issue(EX_BNE, 32'h200, 32'd3, 32'd4, 32'h40);
    tick();
    flush_i = 1'b1;
    alu_busy_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("flush_jump", jump_flag_o, 0);
    chk("flush_valid2", out_valid_o, 0);
    chk("flush_req", alu_req_o, 0);

    // reset during ALU_WAIT
    alu_busy_i = 1'b1;
    issue(EX_ADDI, 32'h0, 32'h55, 32'd0, 32'd1);
    chk("wait_req", alu_req_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    alu_busy_i = 1'b0;
    #1;
    chk("rstw_req", alu_req_o, 0);
    chk("rstw_valid", out_valid_o, 0);
    chk("rstw_ready", in_ready_o, 1);
    issue(EX_ADD, 32'h0, 32'hFFFFFFFF, 32'd2, 32'd0);

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
